// File: rtl/axi_wr_arbiter_if.sv
// Bundle of requester-side and shared AXI write-port signals around the arbiter.
`include "define.sv"

interface axi_wr_arbiter_if #(
    parameter int NREQ      = 2,
    parameter int ADDR_BITS = `ADDR_BITS,
    parameter int LEN_BITS  = `LEN_BITS,
    parameter int SIZE_BITS = `SIZE_BITS,
    parameter int DATA_BITS = `DATA_BITS
);
    localparam int AWI = ADDR_BITS + LEN_BITS + SIZE_BITS + 2;
    localparam int GW  = $clog2(NREQ);

    logic [NREQ-1:0]             req_aw_valid;
    logic [NREQ-1:0]             req_aw_ready;
    logic [NREQ*AWI-1:0]         req_aw_info;
    logic [NREQ-1:0]             req_w_valid;
    logic [NREQ-1:0]             req_w_ready;
    logic [NREQ*DATA_BITS-1:0]   req_w_data;
    logic [NREQ*DATA_BITS/8-1:0] req_w_strb;
    logic [NREQ-1:0]             req_w_last;
    logic [NREQ-1:0]             req_b_valid;
    logic [NREQ-1:0]             req_b_ready;
    logic [1:0]                  req_b_resp;

    logic                        aw_valid;
    logic                        aw_ready;
    logic [ADDR_BITS-1:0]        aw_addr;
    logic [LEN_BITS-1:0]         aw_len;
    logic [SIZE_BITS-1:0]        aw_size;
    logic [1:0]                  aw_burst;
    logic                        w_valid;
    logic                        w_ready;
    logic [DATA_BITS-1:0]        w_data;
    logic [DATA_BITS/8-1:0]      w_strb;
    logic                        w_last;
    logic                        b_valid;
    logic                        b_ready;
    logic [1:0]                  b_resp;

    logic [GW-1:0]               grant_id;
    logic                        busy;

    modport master (
        input  req_aw_valid, req_aw_info, req_w_valid, req_w_data, req_w_strb,
               req_w_last, req_b_ready, aw_ready, w_ready, b_valid, b_resp,
        output req_aw_ready, req_w_ready, req_b_valid, req_b_resp,
               aw_valid, aw_addr, aw_len, aw_size, aw_burst,
               w_valid, w_data, w_strb, w_last, b_ready, grant_id, busy
    );

    modport slave (
        output req_aw_valid, req_aw_info, req_w_valid, req_w_data, req_w_strb,
               req_w_last, req_b_ready, aw_ready, w_ready, b_valid, b_resp,
        input  req_aw_ready, req_w_ready, req_b_valid, req_b_resp,
               aw_valid, aw_addr, aw_len, aw_size, aw_burst,
               w_valid, w_data, w_strb, w_last, b_ready, grant_id, busy
    );
endinterface

// File: rtl/define.sv
// Shared width definitions for the AXI write-port arbiter.
`ifndef AXI_WR_ARBITER_DEFINE_SV
`define AXI_WR_ARBITER_DEFINE_SV
`define ADDR_BITS 32
`define LEN_BITS  8
`define SIZE_BITS 3
`define DATA_BITS 32
`endif

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write port among NREQ requesters,
// one transaction (AW, W burst, B) outstanding at a time.
`include "define.sv"

module axi_wr_arbiter #(
    parameter int NREQ = 2
) (
    input logic               aclk,
    input logic               areset,
    axi_wr_arbiter_if.master  bus
);
    localparam int ADDR_BITS = `ADDR_BITS;
    localparam int LEN_BITS  = `LEN_BITS;
    localparam int SIZE_BITS = `SIZE_BITS;
    localparam int DATA_BITS = `DATA_BITS;
    localparam int STRB_BITS = DATA_BITS / 8;
    localparam int AWI       = ADDR_BITS + LEN_BITS + SIZE_BITS + 2;
    localparam int GW        = $clog2(NREQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [ADDR_BITS-1:0] aw_addr_q, aw_addr_d;
    logic [LEN_BITS-1:0]  aw_len_q, aw_len_d;
    logic [SIZE_BITS-1:0] aw_size_q, aw_size_d;
    logic [1:0]           aw_burst_q, aw_burst_d;

    logic                 any_req;
    logic [GW-1:0]        winner;
    logic [GW-1:0]        cand;
    logic [AWI-1:0]       win_info;

    // Search upward from the requester after last_grant, wrapping to 0.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant_q) + k) % NREQ);
            if (!any_req && bus.req_aw_valid[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    assign win_info = bus.req_aw_info[int'(winner)*AWI +: AWI];

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        aw_addr_d    = aw_addr_q;
        aw_len_d     = aw_len_q;
        aw_size_d    = aw_size_q;
        aw_burst_d   = aw_burst_q;
        case (state_q)
            ST_IDLE: if (any_req) begin
                state_d = ST_ADDR;
                grant_d = winner;
                {aw_addr_d, aw_len_d, aw_size_d, aw_burst_d} = win_info;
            end
            ST_ADDR: if (bus.aw_ready) state_d = ST_DATA;
            ST_DATA: if (bus.req_w_valid[grant_q] && bus.w_ready && bus.req_w_last[grant_q])
                state_d = ST_RESP;
            ST_RESP: if (bus.b_valid && bus.req_b_ready[grant_q]) begin
                state_d      = ST_IDLE;
                last_grant_d = grant_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GW'(NREQ - 1);
            grant_q      <= '0;
            aw_addr_q    <= '0;
            aw_len_q     <= '0;
            aw_size_q    <= '0;
            aw_burst_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            aw_addr_q    <= aw_addr_d;
            aw_len_q     <= aw_len_d;
            aw_size_q    <= aw_size_d;
            aw_burst_q   <= aw_burst_d;
        end
    end

    // No accept pulse while reset is held: the grant could not be registered.
    always_comb begin
        bus.req_aw_ready = '0;
        bus.req_w_ready  = '0;
        bus.req_b_valid  = '0;
        bus.w_valid      = 1'b0;
        bus.b_ready      = 1'b0;
        if (state_q == ST_IDLE && any_req && !areset) bus.req_aw_ready[winner] = 1'b1;
        if (state_q == ST_DATA) begin
            bus.w_valid              = bus.req_w_valid[grant_q];
            bus.req_w_ready[grant_q] = bus.w_ready;
        end
        if (state_q == ST_RESP) begin
            bus.req_b_valid[grant_q] = bus.b_valid;
            bus.b_ready              = bus.req_b_ready[grant_q];
        end
    end

    assign bus.aw_valid   = (state_q == ST_ADDR);
    assign bus.aw_addr    = aw_addr_q;
    assign bus.aw_len     = aw_len_q;
    assign bus.aw_size    = aw_size_q;
    assign bus.aw_burst   = aw_burst_q;
    assign bus.w_data     = bus.req_w_data[int'(grant_q)*DATA_BITS +: DATA_BITS];
    assign bus.w_strb     = bus.req_w_strb[int'(grant_q)*STRB_BITS +: STRB_BITS];
    assign bus.w_last     = bus.req_w_last[grant_q];
    assign bus.req_b_resp = bus.b_resp;
    assign bus.grant_id   = grant_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter with a transaction-phase reference model
// checked every cycle, plus literal expectations per scenario.
`ifndef AXI_WR_ARBITER_DEFINE_SV
`include "define.sv"
`endif

module tb_axi_wr_arbiter;
    localparam int NREQ = 2;
    localparam int AB   = `ADDR_BITS;
    localparam int LB   = `LEN_BITS;
    localparam int SZ   = `SIZE_BITS;
    localparam int DB   = `DATA_BITS;
    localparam int SB   = DB / 8;
    localparam int AWI  = AB + LB + SZ + 2;

    logic aclk = 1'b0;
    logic areset;
    int   n_checks = 0;
    int   n_errors = 0;

    axi_wr_arbiter_if #(.NREQ(NREQ)) bus ();

    axi_wr_arbiter #(.NREQ(NREQ)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int r);
        logic [NREQ-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    // Round robin rule: first valid requester after 'last', wrapping.
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- reference model ----------------
    typedef enum {P_IDLE, P_ADDR, P_DATA, P_RESP} phase_t;
    phase_t         m_phase;
    int             m_owner, m_last, m_gid, m_beats, m_beats_done;
    logic [AWI-1:0] m_aw;
    int             grant_log[$];

    task automatic model_reset();
        m_phase = P_IDLE;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_gid   = 0;
        m_aw    = '0;
        m_beats = 0;
    endtask

    always @(negedge aclk) begin : compare
        int              pick;
        logic [NREQ-1:0] e_awr, e_wr, e_bv;
        logic            e_wv, e_br;
        if (areset) model_reset();
        pick  = rr_pick(m_last, bus.req_aw_valid);
        e_awr = '0;
        if (!areset && m_phase == P_IDLE && pick >= 0) e_awr[pick] = 1'b1;
        e_wv = (m_phase == P_DATA) ? bus.req_w_valid[m_owner] : 1'b0;
        e_wr = '0;
        if (m_phase == P_DATA) e_wr[m_owner] = bus.w_ready;
        e_bv = '0;
        if (m_phase == P_RESP) e_bv[m_owner] = bus.b_valid;
        e_br = (m_phase == P_RESP) ? bus.req_b_ready[m_owner] : 1'b0;

        check("cmp_req_aw_ready", bus.req_aw_ready, e_awr);
        check("cmp_busy", bus.busy, m_phase != P_IDLE);
        check("cmp_grant_id", bus.grant_id, m_gid);
        check("cmp_aw_valid", bus.aw_valid, m_phase == P_ADDR);
        check("cmp_aw_fields", {bus.aw_addr, bus.aw_len, bus.aw_size, bus.aw_burst}, m_aw);
        check("cmp_w_valid", bus.w_valid, e_wv);
        check("cmp_req_w_ready", bus.req_w_ready, e_wr);
        check("cmp_req_b_valid", bus.req_b_valid, e_bv);
        check("cmp_b_ready", bus.b_ready, e_br);
        if (m_phase == P_DATA) begin
            check("cmp_w_data", bus.w_data, bus.req_w_data[m_owner*DB +: DB]);
            check("cmp_w_strb", bus.w_strb, bus.req_w_strb[m_owner*SB +: SB]);
            check("cmp_w_last", bus.w_last, bus.req_w_last[m_owner]);
        end
        if (m_phase == P_RESP) check("cmp_req_b_resp", bus.req_b_resp, bus.b_resp);

        if (!areset) begin
            case (m_phase)
                P_IDLE: if (pick >= 0) begin
                    m_phase = P_ADDR;
                    m_owner = pick;
                    m_gid   = pick;
                    m_aw    = bus.req_aw_info[pick*AWI +: AWI];
                    m_beats = 0;
                    grant_log.push_back(pick);
                end
                P_ADDR: if (bus.aw_ready) m_phase = P_DATA;
                P_DATA: if (e_wv && bus.w_ready) begin
                    m_beats++;
                    if (bus.req_w_last[m_owner]) begin
                        m_phase      = P_RESP;
                        m_beats_done = m_beats;
                    end
                end
                P_RESP: if (bus.b_valid && bus.req_b_ready[m_owner]) begin
                    m_phase = P_IDLE;
                    m_last  = m_owner;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_info(input int r, input logic [AB-1:0] addr, input int nbeats);
        bus.req_aw_info[r*AWI +: AWI] = {addr, LB'(nbeats - 1), SZ'(2), 2'b01};
    endtask

    task automatic wait_grant(input int r);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge aclk);
            if (bus.req_aw_ready[r]) ok = 1'b1;
        end
        check("grant_seen", ok, 1'b1);
        check("grant_onehot", bus.req_aw_ready, onehot(r));
        check("grant_busy", bus.busy, 1'b0);
    endtask

    task automatic run_txn(input int r, input logic [AB-1:0] addr, input int nbeats,
                           input int aw_stall, input bit w_toggle, input int b_stall,
                           input bit keep_req, input logic [1:0] resp);
        int sent;
        int cyc;
        bit tog;
        set_info(r, addr, nbeats);
        bus.req_aw_valid[r] = 1'b1;
        bus.aw_ready        = (aw_stall == 0);
        wait_grant(r);
        tick();
        if (!keep_req) bus.req_aw_valid[r] = 1'b0;
        for (int i = 0; i < aw_stall; i++) begin
            @(negedge aclk);
            check("addr_hold_valid", bus.aw_valid, 1'b1);
            check("addr_hold_addr", bus.aw_addr, addr);
            check("addr_hold_len", bus.aw_len, nbeats - 1);
            check("addr_hold_w_ready", bus.req_w_ready, '0);
            tick();
        end
        bus.aw_ready = 1'b1;
        @(negedge aclk);
        check("addr_aw_valid", bus.aw_valid, 1'b1);
        check("addr_aw_addr", bus.aw_addr, addr);
        check("addr_req_aw_ready", bus.req_aw_ready, '0);
        check("addr_grant_id", bus.grant_id, r);
        tick();
        bus.aw_ready = 1'b0;
        // one bubble cycle in DATA before the first beat
        bus.req_w_valid[r] = 1'b0;
        bus.w_ready        = 1'b1;
        @(negedge aclk);
        check("bubble_w_valid", bus.w_valid, 1'b0);
        check("bubble_req_w_ready", bus.req_w_ready, onehot(r));
        tick();
        sent = 0;
        cyc  = 0;
        tog  = 1'b0;
        while (sent < nbeats && cyc < 64) begin
            bus.req_w_valid[r]          = 1'b1;
            bus.req_w_data[r*DB +: DB]  = DB'(addr) + DB'(sent);
            bus.req_w_strb[r*SB +: SB]  = SB'(sent + 1);
            bus.req_w_last[r]           = (sent == nbeats - 1);
            bus.w_ready                 = w_toggle ? tog : 1'b1;
            tog                         = !tog;
            @(negedge aclk);
            check("beat_w_valid", bus.w_valid, 1'b1);
            if (bus.w_ready) sent++;
            tick();
            cyc++;
        end
        check("beats_sent", sent, nbeats);
        bus.req_w_valid[r] = 1'b0;
        bus.req_w_last[r]  = 1'b0;
        bus.w_ready        = 1'b0;
        bus.b_valid        = 1'b1;
        bus.b_resp         = resp;
        bus.req_b_ready[r] = 1'b0;
        for (int i = 0; i < b_stall; i++) begin
            @(negedge aclk);
            check("resp_hold_b_ready", bus.b_ready, 1'b0);
            check("resp_hold_busy", bus.busy, 1'b1);
            check("resp_b_valid_only_g", bus.req_b_valid, onehot(r));
            tick();
        end
        bus.req_b_ready[r] = 1'b1;
        @(negedge aclk);
        check("resp_b_ready", bus.b_ready, 1'b1);
        check("resp_code", bus.req_b_resp, resp);
        tick();
        bus.b_valid        = 1'b0;
        bus.req_b_ready[r] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int exp_seq[4];
        exp_seq = '{0, 1, 0, 1};
        areset = 1'b1;
        bus.req_aw_valid = '0;  bus.req_aw_info = '0;
        bus.req_w_valid  = '0;  bus.req_w_data  = '0;
        bus.req_w_strb   = '0;  bus.req_w_last  = '0;
        bus.req_b_ready  = '0;
        bus.aw_ready = 1'b0;  bus.w_ready = 1'b0;
        bus.b_valid  = 1'b0;  bus.b_resp  = 2'b00;
        repeat (3) tick();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_aw_addr", bus.aw_addr, 0);
        areset = 1'b0;

        // Single requester: addr 0x100, 4 beats, OKAY
        run_txn(0, 32'h100, 4, 0, 1'b0, 0, 1'b0, 2'b00);
        @(negedge aclk);
        check("s1_busy_after_b", bus.busy, 1'b0);
        check("s1_beats", m_beats_done, 4);
        tick();

        // Requester 1 alone: AW stall 5, toggling w_ready, B stall 3, SLVERR
        run_txn(1, 32'h2000, 3, 5, 1'b1, 3, 1'b0, 2'b10);
        check("s2_beats", m_beats_done, 3);
        tick();

        // Isolation: requester 1 drives W and B signals while 0 is granted
        bus.req_w_valid[1]         = 1'b1;
        bus.req_w_last[1]          = 1'b1;
        bus.req_w_data[DB +: DB]   = 32'hDEAD_BEEF;
        bus.req_w_strb[SB +: SB]   = '1;
        bus.req_b_ready[1]         = 1'b1;
        run_txn(0, 32'h3000, 2, 1, 1'b0, 2, 1'b0, 2'b00);
        bus.req_w_valid[1] = 1'b0;
        bus.req_w_last[1]  = 1'b0;
        bus.req_b_ready[1] = 1'b0;
        tick();

        // Reset in DATA with w_valid high
        set_info(0, 32'h200, 2);
        bus.req_aw_valid[0] = 1'b1;
        bus.aw_ready        = 1'b1;
        wait_grant(0);
        tick();
        bus.req_aw_valid[0] = 1'b0;
        tick();
        bus.aw_ready        = 1'b0;
        bus.req_w_valid[0]  = 1'b1;
        bus.w_ready         = 1'b0;
        bus.b_valid         = 1'b1;
        bus.req_b_ready[0]  = 1'b1;
        @(negedge aclk);
        check("pre_rst_w_valid", bus.w_valid, 1'b1);
        tick();
        areset = 1'b1;
        #1;
        check("rst_mid_aw_valid", bus.aw_valid, 1'b0);
        check("rst_mid_w_valid", bus.w_valid, 1'b0);
        check("rst_mid_b_ready", bus.b_ready, 1'b0);
        check("rst_mid_busy", bus.busy, 1'b0);
        bus.req_w_valid[0] = 1'b0;
        bus.b_valid        = 1'b0;
        bus.req_b_ready[0] = 1'b0;
        bus.req_aw_valid   = '1;
        set_info(0, 32'h300, 1);
        set_info(1, 32'h400, 2);
        grant_log.delete();
        tick();
        areset = 1'b0;

        // Fairness: both requesters hold aw_valid for 4 transactions
        run_txn(0, 32'h300, 1, 0, 1'b0, 0, 1'b1, 2'b00);
        run_txn(1, 32'h400, 2, 0, 1'b1, 1, 1'b1, 2'b01);
        run_txn(0, 32'h500, 1, 0, 1'b0, 0, 1'b1, 2'b00);
        run_txn(1, 32'h600, 1, 1, 1'b0, 0, 1'b1, 2'b11);
        bus.req_aw_valid = '0;
        tick();
        tick();
        check("fair_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("fair_seq", grant_log[i], exp_seq[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
